e203_exu_oitf_trk: RTL

//  Outstanding Instruction Track FIFO on the receiving end of the EXU dispatch->OITF interface.
//  - Allocates one entry per long-pipe dispatch and returns the itag (pointer) of that entry.
//  - Reports RAW/WAW register matches against all live entries, which dispatch uses to stall.
//  - Retires entries in order as long-pipe units write back; supplies the oldest entry's rd/pc to writeback.

---
 rtl/e203_exu_oitf_trk.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/e203_exu_oitf_trk.sv
// Outstanding Instruction Track FIFO (OITF).
// Circular buffer of in-flight long-pipe instructions: allocated at dispatch,
// retired in order at long-pipe writeback. Supplies RAW/WAW register matches
// against every live entry so dispatch can stall on hazards.
module e203_exu_oitf_trk #(
    parameter int OITF_DEPTH  = 2,
    parameter int ITAG_WIDTH  = 1,
    parameter int RFIDX_WIDTH = 5,
    parameter int PC_SIZE     = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,

    input  logic                   disp_oitf_ena,
    output logic                   disp_oitf_ready,
    output logic [ITAG_WIDTH-1:0]  disp_oitf_ptr,

    input  logic                   disp_oitf_rs1en,
    input  logic                   disp_oitf_rs2en,
    input  logic                   disp_oitf_rs3en,
    input  logic                   disp_oitf_rs1fpu,
    input  logic                   disp_oitf_rs2fpu,
    input  logic                   disp_oitf_rs3fpu,
    input  logic [RFIDX_WIDTH-1:0] disp_oitf_rs1idx,
    input  logic [RFIDX_WIDTH-1:0] disp_oitf_rs2idx,
    input  logic [RFIDX_WIDTH-1:0] disp_oitf_rs3idx,
    input  logic                   disp_oitf_rdwen,
    input  logic                   disp_oitf_rdfpu,
    input  logic [RFIDX_WIDTH-1:0] disp_oitf_rdidx,
    input  logic [PC_SIZE-1:0]     disp_oitf_pc,

    output logic                   oitfrd_match_disprs1,
    output logic                   oitfrd_match_disprs2,
    output logic                   oitfrd_match_disprs3,
    output logic                   oitfrd_match_disprd,

    input  logic                   oitf_ret_ena,
    output logic [ITAG_WIDTH-1:0]  oitf_ret_ptr,
    output logic                   oitf_ret_rdwen,
    output logic                   oitf_ret_rdfpu,
    output logic [RFIDX_WIDTH-1:0] oitf_ret_rdidx,
    output logic [PC_SIZE-1:0]     oitf_ret_pc,

    output logic                   oitf_empty
);

    localparam logic [ITAG_WIDTH-1:0] LAST_PTR = ITAG_WIDTH'(OITF_DEPTH - 1);

    logic [OITF_DEPTH-1:0]  vld;
    logic [OITF_DEPTH-1:0]  rdwen_q;
    logic [OITF_DEPTH-1:0]  rdfpu_q;
    logic [RFIDX_WIDTH-1:0] rdidx_q [OITF_DEPTH];
    logic [PC_SIZE-1:0]     pc_q    [OITF_DEPTH];

    logic [ITAG_WIDTH-1:0]  alc_ptr;
    logic [ITAG_WIDTH-1:0]  ret_ptr;
    logic                   alc_flg;
    logic                   ret_flg;

    logic ptr_eq;
    logic empty;
    logic full;
    logic alc_ena;
    logic ret_ena;

    // Pointers equal: the wrap flags tell an empty buffer from a full one.
    assign ptr_eq  = (alc_ptr == ret_ptr);
    assign empty   = ptr_eq & (alc_flg == ret_flg);
    assign full    = ptr_eq & (alc_flg != ret_flg);

    // Requests that cannot be honoured are dropped here; no same-cycle bypass of a freed slot.
    assign alc_ena = disp_oitf_ena & ~full;
    assign ret_ena = oitf_ret_ena & ~empty;

    assign disp_oitf_ready = ~full;
    assign disp_oitf_ptr   = alc_ptr;
    assign oitf_empty      = empty;

    // Allocation pointer advances on each accepted dispatch, toggling its flag on wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alc_ptr <= '0;
            alc_flg <= 1'b0;
        end else if (alc_ena) begin
            if (alc_ptr == LAST_PTR) begin
                alc_ptr <= '0;
                alc_flg <= ~alc_flg;
            end else begin
                alc_ptr <= alc_ptr + ITAG_WIDTH'(1);
            end
        end
    end

    // Retire pointer advances on each accepted writeback, toggling its flag on wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ret_ptr <= '0;
            ret_flg <= 1'b0;
        end else if (ret_ena) begin
            if (ret_ptr == LAST_PTR) begin
                ret_ptr <= '0;
                ret_flg <= ~ret_flg;
            end else begin
                ret_ptr <= ret_ptr + ITAG_WIDTH'(1);
            end
        end
    end

    // Entry storage: allocation fills the slot at alc_ptr, retirement clears vld at ret_ptr.
    // The two never address the same slot in one cycle (that would need both empty and full).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld     <= '0;
            rdwen_q <= '0;
            rdfpu_q <= '0;
            for (int i = 0; i < OITF_DEPTH; i++) begin
                rdidx_q[i] <= '0;
                pc_q[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < OITF_DEPTH; i++) begin
                if (ret_ena && (ret_ptr == ITAG_WIDTH'(i))) begin
                    vld[i] <= 1'b0;
                end
                if (alc_ena && (alc_ptr == ITAG_WIDTH'(i))) begin
                    vld[i]     <= 1'b1;
                    rdwen_q[i] <= disp_oitf_rdwen;
                    rdfpu_q[i] <= disp_oitf_rdfpu;
                    rdidx_q[i] <= disp_oitf_rdidx;
                    pc_q[i]    <= disp_oitf_pc;
                end
            end
        end
    end

    // Hazard matches use registered entries only, so a same-cycle allocation is not seen yet.
    always_comb begin
        oitfrd_match_disprs1 = 1'b0;
        oitfrd_match_disprs2 = 1'b0;
        oitfrd_match_disprs3 = 1'b0;
        oitfrd_match_disprd  = 1'b0;
        for (int i = 0; i < OITF_DEPTH; i++) begin
            if (vld[i] && rdwen_q[i]) begin
                if (disp_oitf_rs1en && (rdidx_q[i] == disp_oitf_rs1idx) && (rdfpu_q[i] == disp_oitf_rs1fpu))
                    oitfrd_match_disprs1 = 1'b1;
                if (disp_oitf_rs2en && (rdidx_q[i] == disp_oitf_rs2idx) && (rdfpu_q[i] == disp_oitf_rs2fpu))
                    oitfrd_match_disprs2 = 1'b1;
                if (disp_oitf_rs3en && (rdidx_q[i] == disp_oitf_rs3idx) && (rdfpu_q[i] == disp_oitf_rs3fpu))
                    oitfrd_match_disprs3 = 1'b1;
                if (disp_oitf_rdwen && (rdidx_q[i] == disp_oitf_rdidx) && (rdfpu_q[i] == disp_oitf_rdfpu))
                    oitfrd_match_disprd = 1'b1;
            end
        end
    end

    // Oldest entry is read straight out of storage; meaningful only while not empty.
    assign oitf_ret_ptr   = ret_ptr;
    assign oitf_ret_rdwen = rdwen_q[ret_ptr];
    assign oitf_ret_rdfpu = rdfpu_q[ret_ptr];
    assign oitf_ret_rdidx = rdidx_q[ret_ptr];
    assign oitf_ret_pc    = pc_q[ret_ptr];

`ifndef SYNTHESIS
    // Flag protocol violations in simulation; the logic above already ignores them.
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(disp_oitf_ena && full))
                else $warning("oitf: allocate request while full was ignored");
            assert (!(oitf_ret_ena && empty))
                else $warning("oitf: retire request while empty was ignored");
        end
    end
`endif

endmodule
